// File: rtl/branch_update_arbiter_pkg.sv
// branch_update_arbiter_pkg: shared state codes, counter encodings and branch info layout
package branch_update_arbiter_pkg;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  typedef enum logic [1:0] {SNT = 2'd0, WNT = 2'd1, WT = 2'd2, ST = 2'd3} bctr_e;
  typedef struct packed {
    logic dir;
    logic [1:0] typ;
    logic [31:0] tar;
  } branch_info_t;
endpackage

// File: rtl/bu_fifo2w1r.sv
// bu_fifo2w1r: in-order FIFO accepting up to two writes and one read per cycle
module bu_fifo2w1r #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic we0,
  input  logic [W-1:0] wd0,
  input  logic we1,
  input  logic [W-1:0] wd1,
  input  logic re,
  output logic [W-1:0] rd,
  output logic [$clog2(DEPTH):0] count,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp, wp1;
  assign wp1 = wp + 1'b1;
  assign rd = mem[rp[AW-1:0]];
  assign count = wp - rp;
  assign empty = wp == rp;
  // a lone write1 takes the first free slot so the queue never has holes
  always_ff @(posedge clk) begin
    if (we0 || we1) mem[wp[AW-1:0]] <= we0 ? wd0 : wd1;
    if (we0 && we1) mem[wp1[AW-1:0]] <= wd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp + PW'(we0) + PW'(we1);
      rp <= rp + PW'(re && !empty);
    end
endmodule

// File: rtl/branch_update_arbiter.sv
// branch_update_arbiter: clears the branch buffer after reset, then issues queued EX updates one per cycle
module branch_update_arbiter
  import branch_update_arbiter_pkg::*;
#(
  parameter int TAG_W = 22,
  parameter int IDX_W = 8,
  parameter int INFO_W = 35,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic upd0_valid,
  input  logic [TAG_W-1:0] upd0_tag,
  input  logic [IDX_W-1:0] upd0_index,
  input  logic [INFO_W-1:0] upd0_info,
  input  logic upd0_hit,
  input  logic upd1_valid,
  input  logic [TAG_W-1:0] upd1_tag,
  input  logic [IDX_W-1:0] upd1_index,
  input  logic [INFO_W-1:0] upd1_info,
  input  logic upd1_hit,
  output logic upd_ready,
  output logic bb_we,
  output logic bb_clr,
  output logic [TAG_W-1:0] bb_tag,
  output logic [IDX_W-1:0] bb_index,
  output logic [INFO_W-1:0] bb_info,
  output logic bb_pred_flag,
  output logic init_done
);
  localparam int EW = 1 + TAG_W + IDX_W + INFO_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [0:0] state, state_n;
  logic [IDX_W-1:0] cnt;
  logic push0, push1, pop, empty;
  logic [CW-1:0] count, count_n;
  logic [EW-1:0] head;
  logic h_hit;
  logic [TAG_W-1:0] h_tag;
  logic [IDX_W-1:0] h_index;
  logic [INFO_W-1:0] h_info;
  assign push0 = upd_ready && upd0_valid;
  assign push1 = upd_ready && upd1_valid;
  assign pop = (state == RUN) && !empty;
  assign state_n = (state == INIT && cnt == '1) ? RUN : state;
  assign count_n = count + CW'(push0) + CW'(push1) - CW'(pop);
  assign {h_hit, h_tag, h_index, h_info} = head;
  bu_fifo2w1r #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .we0(push0),
    .wd0({upd0_hit, upd0_tag, upd0_index, upd0_info}),
    .we1(push1),
    .wd1({upd1_hit, upd1_tag, upd1_index, upd1_info}),
    .re(pop),
    .rd(head),
    .count(count),
    .empty(empty)
  );
  // ready looks at end-of-cycle occupancy so next cycle's two pushes always fit
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= INIT;
      cnt <= '0;
      upd_ready <= 1'b0;
      init_done <= 1'b0;
      bb_we <= 1'b0;
      bb_clr <= 1'b0;
      bb_tag <= '0;
      bb_index <= '0;
      bb_info <= '0;
      bb_pred_flag <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt + IDX_W'(state == INIT);
      init_done <= state == RUN;
      upd_ready <= (state == RUN) && (count_n <= CW'(DEPTH - 2));
      bb_we <= (state == INIT) || pop;
      bb_clr <= state == INIT;
      bb_index <= (state == INIT) ? cnt : pop ? h_index : '0;
      bb_tag <= pop ? h_tag : '0;
      bb_info <= pop ? h_info : '0;
      bb_pred_flag <= pop && h_hit;
    end
  assert property (@(posedge clk) disable iff (rst)
    (state == RUN && !upd_ready) |-> !(upd0_valid || upd1_valid));
endmodule

// File: tb/tb_branch_update_arbiter.sv
// tb_branch_update_arbiter: directed vectors plus random traffic against a write-schedule model
module tb_branch_update_arbiter;
  import branch_update_arbiter_pkg::*;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst;
  logic upd0_valid, upd0_hit, upd1_valid, upd1_hit;
  logic [21:0] upd0_tag, upd1_tag;
  logic [7:0] upd0_index, upd1_index;
  logic [34:0] upd0_info, upd1_info;
  logic upd_ready, bb_we, bb_clr, bb_pred_flag, init_done;
  logic [21:0] bb_tag;
  logic [7:0] bb_index;
  logic [34:0] bb_info;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_t = 0;
  typedef struct {
    logic v0, h0, v1, h1;
    logic [21:0] t0, t1;
    logic [7:0] i0, i1;
    logic [34:0] f0, f1;
  } in_t;
  typedef struct {
    logic [21:0] tag;
    logic [7:0] idx;
    logic [34:0] info;
    logic hit;
    int t;
  } ent_t;
  typedef struct {
    in_t a;
    int nw;
    logic [7:0] e_idx;
    logic [21:0] e_tag;
    logic [34:0] e_info0, e_info1;
    logic e_hit;
  } vec_t;
  ent_t q[$];
  ent_t seen[$];
  vec_t vt[4];
  in_t idle, a;
  branch_info_t bi_a, bi_b, bi_c, bi_d;

  branch_update_arbiter dut (
    .clk(clk), .rst(rst),
    .upd0_valid(upd0_valid), .upd0_tag(upd0_tag), .upd0_index(upd0_index), .upd0_info(upd0_info), .upd0_hit(upd0_hit),
    .upd1_valid(upd1_valid), .upd1_tag(upd1_tag), .upd1_index(upd1_index), .upd1_info(upd1_info), .upd1_hit(upd1_hit),
    .upd_ready(upd_ready), .bb_we(bb_we), .bb_clr(bb_clr), .bb_tag(bb_tag), .bb_index(bb_index),
    .bb_info(bb_info), .bb_pred_flag(bb_pred_flag), .init_done(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk or posedge rst) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // an entry issues no earlier than two cycles after acceptance and one after its predecessor
  function automatic bit model_ready(input int c);
    int n = 0;
    foreach (q[k]) if (q[k].t > c) n++;
    return n <= DEPTH - 2;
  endfunction

  task automatic push(input logic [21:0] tag, input logic [7:0] idx, input logic [34:0] info, input logic hit);
    int t = (cyc + 2 > last_t + 1) ? cyc + 2 : last_t + 1;
    last_t = t;
    q.push_back('{tag, idx, info, hit, t});
  endtask

  function automatic in_t rand_in();
    in_t r;
    r.v0 = 1'($urandom_range(0, 1));
    r.v1 = 1'($urandom_range(0, 1));
    r.h0 = 1'($urandom_range(0, 1));
    r.h1 = 1'($urandom_range(0, 1));
    r.t0 = 22'($urandom);
    r.t1 = 22'($urandom);
    r.i0 = 8'($urandom);
    r.i1 = 8'($urandom);
    r.f0 = {3'($urandom_range(0, 7)), 32'($urandom)};
    r.f1 = {3'($urandom_range(0, 7)), 32'($urandom)};
    return r;
  endfunction

  task automatic drive(input in_t d);
    upd0_valid = d.v0; upd0_tag = d.t0; upd0_index = d.i0; upd0_info = d.f0; upd0_hit = d.h0;
    upd1_valid = d.v1; upd1_tag = d.t1; upd1_index = d.i1; upd1_info = d.f1; upd1_hit = d.h1;
  endtask

  task automatic check_cycle();
    int c = cyc;
    bit exp_we;
    if (c <= 256) begin
      chk("sweep_we", 64'(bb_we), 64'd1);
      chk("sweep_clr", 64'(bb_clr), 64'd1);
      chk("sweep_index", 64'(bb_index), 64'(c - 1));
      chk("sweep_done", 64'(init_done), 64'd0);
      chk("sweep_ready", 64'(upd_ready), 64'd0);
      chk("sweep_payload", 64'({bb_pred_flag, bb_tag, bb_info}), 64'd0);
    end else begin
      exp_we = q.size() > 0 && q[0].t == c;
      chk("run_done", 64'(init_done), 64'd1);
      chk("run_clr", 64'(bb_clr), 64'd0);
      chk("run_ready", 64'(upd_ready), 64'(model_ready(c)));
      chk("run_we", 64'(bb_we), 64'(exp_we));
      if (bb_we) seen.push_back('{bb_tag, bb_index, bb_info, bb_pred_flag, c});
      if (exp_we) begin
        chk("wr_index", 64'(bb_index), 64'(q[0].idx));
        chk("wr_tag", 64'(bb_tag), 64'(q[0].tag));
        chk("wr_info", 64'(bb_info), 64'(q[0].info));
        chk("wr_pred", 64'(bb_pred_flag), 64'(q[0].hit));
        void'(q.pop_front());
      end
    end
  endtask

  task automatic step(input in_t s);
    bit acc;
    in_t d = s;
    @(negedge clk);
    check_cycle();
    acc = cyc >= 257 && model_ready(cyc);
    if (cyc >= 256 && !acc) begin
      d.v0 = 1'b0;
      d.v1 = 1'b0;
    end
    drive(d);
    if (acc && d.v0) push(d.t0, d.i0, d.f0, d.h0);
    if (acc && d.v1) push(d.t1, d.i1, d.f1, d.h1);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) step(idle);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d writes still pending", q.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(idle);
    #1;
    chk("rst_we", 64'(bb_we), 64'd0);
    chk("rst_clr", 64'(bb_clr), 64'd0);
    chk("rst_ready", 64'(upd_ready), 64'd0);
    chk("rst_done", 64'(init_done), 64'd0);
    chk("rst_payload", 64'({bb_pred_flag, bb_tag, bb_index, bb_info}), 64'd0);
    q.delete();
    last_t = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    idle = '{default: 0};
    rst = 1'b0;
    drive(idle);
    bi_a = '{dir: 1'b0, typ: 2'b01, tar: 32'h8000_0040};
    bi_b = '{dir: 1'b1, typ: 2'b00, tar: 32'h0000_1000};
    bi_c = '{dir: 1'b0, typ: 2'b10, tar: 32'h0000_2000};
    bi_d = '{dir: 1'b1, typ: 2'b11, tar: 32'hDEAD_BEE0};
    vt[0] = '{a: idle, nw: 1, e_idx: 8'h12, e_tag: 22'h3A5, e_info0: bi_a, e_info1: '0, e_hit: 1'b0};
    vt[0].a.v0 = 1'b1; vt[0].a.t0 = 22'h3A5; vt[0].a.i0 = 8'h12; vt[0].a.f0 = bi_a;
    vt[1] = '{a: idle, nw: 2, e_idx: 8'h05, e_tag: 22'h10, e_info0: bi_b, e_info1: bi_c, e_hit: 1'b1};
    vt[1].a.v0 = 1'b1; vt[1].a.t0 = 22'h10; vt[1].a.i0 = 8'h05; vt[1].a.f0 = bi_b; vt[1].a.h0 = 1'b1;
    vt[1].a.v1 = 1'b1; vt[1].a.t1 = 22'h11; vt[1].a.i1 = 8'h05; vt[1].a.f1 = bi_c;
    vt[2] = '{a: idle, nw: 1, e_idx: 8'h77, e_tag: 22'h2AA, e_info0: bi_d, e_info1: '0, e_hit: 1'b1};
    vt[2].a.t0 = 22'h155; vt[2].a.i0 = 8'h99; vt[2].a.f0 = bi_a;
    vt[2].a.v1 = 1'b1; vt[2].a.t1 = 22'h2AA; vt[2].a.i1 = 8'h77; vt[2].a.f1 = bi_d; vt[2].a.h1 = 1'b1;
    vt[3] = '{a: idle, nw: 0, e_idx: 8'h00, e_tag: 22'h0, e_info0: '0, e_info1: '0, e_hit: 1'b0};
    vt[3].a.i0 = 8'h33; vt[3].a.i1 = 8'h44; vt[3].a.h0 = 1'b1;
    @(negedge clk);
    do_reset();
    // updates offered during the sweep must be ignored
    repeat (256) step(rand_in());
    foreach (vt[k]) begin
      drain();
      seen.delete();
      step(vt[k].a);
      repeat (4) step(idle);
      chk($sformatf("vec%0d_writes", k), 64'(seen.size()), 64'(vt[k].nw));
      if (seen.size() > 0 && vt[k].nw > 0) begin
        chk($sformatf("vec%0d_idx", k), 64'(seen[0].idx), 64'(vt[k].e_idx));
        chk($sformatf("vec%0d_tag", k), 64'(seen[0].tag), 64'(vt[k].e_tag));
        chk($sformatf("vec%0d_info0", k), 64'(seen[0].info), 64'(vt[k].e_info0));
        chk($sformatf("vec%0d_hit", k), 64'(seen[0].hit), 64'(vt[k].e_hit));
      end
      if (seen.size() > 1 && vt[k].nw > 1) chk($sformatf("vec%0d_info1", k), 64'(seen[1].info), 64'(vt[k].e_info1));
    end
    drain();
    seen.delete();
    a = rand_in();
    a.v0 = 1'b1; a.v1 = 1'b1; a.i0 = 8'h41; a.i1 = 8'h42;
    step(a);
    a.i0 = 8'h43; a.i1 = 8'h44;
    step(a);
    a.i0 = 8'h45; a.i1 = 8'h46;
    step(a);
    chk("t4_ready_low", 64'(upd_ready), 64'd0);
    drain();
    chk("t4_writes", 64'(seen.size()), 64'd4);
    for (int k = 0; k < 4 && k < seen.size(); k++) chk("t4_order", 64'(seen[k].idx), 64'(8'h41 + k));
    repeat (400) step(rand_in());
    drain();
    a = rand_in();
    a.v0 = 1'b1; a.v1 = 1'b1;
    step(a);
    step(a);
    @(negedge clk);
    do_reset();
    repeat (256) step(idle);
    seen.delete();
    repeat (10) step(idle);
    chk("t6_no_stale_write", 64'(seen.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
